// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: mode encodings, LED seeds and counter widths.
package led_seq_pkg;

  localparam int LED_W  = 4;
  localparam int TICK_W = 24;
  localparam int DEB_W  = 20;

  typedef enum logic [1:0] {
    MODE_FLOW_L = 2'd0,
    MODE_FLOW_R = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] SEED_FLOW_L = 4'b0001;
  localparam logic [LED_W-1:0] SEED_FLOW_R = 4'b1000;
  localparam logic [LED_W-1:0] SEED_BLINK  = 4'b1111;
  localparam logic [LED_W-1:0] SEED_BOUNCE = 4'b0001;

  function automatic logic [LED_W-1:0] seed_of(input mode_e m);
    case (m)
      MODE_FLOW_L: seed_of = SEED_FLOW_L;
      MODE_FLOW_R: seed_of = SEED_FLOW_R;
      MODE_BLINK:  seed_of = SEED_BLINK;
      default:     seed_of = SEED_BOUNCE;
    endcase
  endfunction

endpackage

// File: rtl/key_press.sv
// Key conditioning: 2-flop synchronizer, then one registered press pulse per press.
// With LED_SEQ_DEBOUNCE_EN defined the pulse needs DEB_MAX+1 stable-low cycles; otherwise it is the falling edge.
module key_press
  import led_seq_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_MAX = 20'd1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press
);

  logic [1:0] sync_q;
  logic       key_q;
  logic       press_q;
  logic       press_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q  <= 2'b11;
      key_q   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the synchronizer chain.
      sync_q  <= {sync_q[0], key_n};
      key_q   <= sync_q[1];
      press_q <= press_d;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned, which would infer a latch.
    cnt_d   = cnt_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (key_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == DEB_MAX) begin
        press_d = 1'b1;
        armed_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end
`else
  logic key_prev_q;
  logic deb_max_unused;

  assign deb_max_unused = ^DEB_MAX;
  assign press_d        = key_prev_q & ~key_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) key_prev_q <= 1'b1;
    else            key_prev_q <= key_q;
  end
`endif

  assign press = press_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Four-LED pattern sequencer with mode/pause keys, prescaled step timing and registered outputs.
// Optional key debounce is enabled by defining LED_SEQ_DEBOUNCE_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter logic [TICK_W-1:0] TICK_MAX = 24'd10_000_000,
  parameter logic [DEB_W-1:0]  DEB_MAX  = 20'd1_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             key_mode,
  input  logic             key_pause,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             paused,
  output logic             step_tick
);

  logic mode_press;
  logic pause_press;

  key_press #(.DEB_MAX(DEB_MAX)) u_key_mode (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (key_mode),
    .press    (mode_press)
  );

  key_press #(.DEB_MAX(DEB_MAX)) u_key_pause (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (key_pause),
    .press    (pause_press)
  );

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0]  led_q, led_d;
  mode_e             mode_q, mode_d;
  dir_e              dir_q, dir_d;
  logic              paused_q, paused_d;
  logic              step_tick_q, step_tick_d;

  always_comb begin
    cnt_d       = cnt_q;
    led_d       = led_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    step_tick_d = 1'b0;
    paused_d    = paused_q ^ pause_press;
    // A mode press reseeds and restarts timing, and wins over a coincident wrap.
    if (mode_press) begin
      mode_d = mode_e'(mode_q + 2'd1);
      led_d  = seed_of(mode_d);
      dir_d  = DIR_LEFT;
      cnt_d  = '0;
    end else if (!paused_q) begin
      if (cnt_q == TICK_MAX) begin
        cnt_d       = '0;
        step_tick_d = 1'b1;
        case (mode_q)
          MODE_FLOW_L: led_d = {led_q[2:0], led_q[3]};
          MODE_FLOW_R: led_d = {led_q[0], led_q[3:1]};
          MODE_BLINK:  led_d = ~led_q;
          default: begin
            // Endpoints are shown once, then the direction turns.
            if (dir_q == DIR_LEFT) begin
              if (led_q == 4'b1000) begin
                led_d = 4'b0100;
                dir_d = DIR_RIGHT;
              end else begin
                led_d = {led_q[2:0], 1'b0};
              end
            end else if (led_q == 4'b0001) begin
              led_d = 4'b0010;
              dir_d = DIR_LEFT;
            end else begin
              led_d = {1'b0, led_q[3:1]};
            end
          end
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= '0;
      led_q       <= SEED_FLOW_L;
      mode_q      <= MODE_FLOW_L;
      dir_q       <= DIR_LEFT;
      paused_q    <= 1'b0;
      step_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      paused_q    <= paused_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign led       = led_q;
  assign mode      = mode_q;
  assign paused    = paused_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_MAX=10, DEB_MAX=4; timing follows the LED_SEQ_DEBOUNCE_EN build.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int LAT  = 9;  // drive negedge to output change: 2 sync + 5 debounce samples + pulse + update
  localparam int HOLD = 8;
`else
  localparam int LAT  = 5;
  localparam int HOLD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_pause = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       step_tick;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  led_seq_ctrl #(.TICK_MAX(24'd10), .DEB_MAX(20'd4)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key_mode (key_mode),
    .key_pause(key_pause),
    .led      (led),
    .mode     (mode),
    .paused   (paused),
    .step_tick(step_tick)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_to(input int t);
    if (t > cyc) tick(t - cyc);
  endtask

  task automatic press(input bit on_mode, input bit on_pause, input int hold);
    if (on_mode)  key_mode  = 1'b0;
    if (on_pause) key_pause = 1'b0;
    tick(hold);
    key_mode  = 1'b1;
    key_pause = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    key_mode  = 1'b1;
    key_pause = 1'b1;
    #1;
    check("rst_led", led, 4'b0001);
    check("rst_mode", mode, 2'd0);
    check("rst_paused", paused, 1'b0);
    check("rst_tick", step_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  logic [3:0] exp_flow[4]   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_bounce[6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  int t4;
  int t_mp;
  int n_tick;
  int n_led_chg;

  initial begin
    // Free-running FLOW_L after reset release.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      wait_to(11 * k - 1);
      check("free_no_tick", step_tick, 1'b0);
      wait_to(11 * k);
      check("free_tick", step_tick, 1'b1);
      check("free_led", led, exp_flow[k-1]);
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    // A 3-cycle press is shorter than the debounce window.
    do_reset();
    press(1'b1, 1'b0, 3);
    wait_to(12);
    check("short_mode", mode, 2'd0);
    check("short_led", led, 4'b0010);
`endif

    // Mode presses: first lands exactly on a prescaler wrap.
    do_reset();
    wait_to(11 - LAT);
    press(1'b1, 1'b0, HOLD);
    wait_to(10);
    check("lat_mode_before", mode, 2'd0);
    wait_to(11);
    check("m1_mode", mode, 2'd1);
    check("m1_led", led, 4'b1000);
    check("m1_wrap_no_tick", step_tick, 1'b0);
    wait_to(22);
    check("m1_tick", step_tick, 1'b1);
    check("m1_step1", led, 4'b0100);
    wait_to(33);
    check("m1_step2", led, 4'b0010);
    wait_to(40);
    press(1'b1, 1'b0, HOLD);
    wait_to(40 + LAT);
    check("m2_mode", mode, 2'd2);
    check("m2_led", led, 4'b1111);
    wait_to(40 + LAT + 11);
    check("m2_tick", step_tick, 1'b1);
    check("m2_step", led, 4'b0000);
    wait_to(60);
    press(1'b1, 1'b0, HOLD);
    wait_to(60 + LAT);
    check("m3_mode", mode, 2'd3);
    check("m3_led", led, 4'b0001);
    for (int k = 1; k <= 6; k++) begin
      wait_to(60 + LAT + 11 * k);
      check("bounce_led", led, exp_bounce[k-1]);
    end
    t4 = 60 + LAT + 70;
    wait_to(t4);
    press(1'b1, 1'b0, HOLD);
    wait_to(t4 + LAT);
    check("m4_wrap_mode", mode, 2'd0);
    check("m4_led", led, 4'b0001);

    // Pause at prescaler 5 with led 0100, hold, resume.
    do_reset();
    wait_to(27 - LAT);
    press(1'b0, 1'b1, HOLD);
    wait_to(27);
    check("pause_on", paused, 1'b1);
    check("pause_led", led, 4'b0100);
    n_tick    = 0;
    n_led_chg = 0;
    while (cyc < 77) begin
      tick(1);
      if (step_tick) n_tick++;
      if (led != 4'b0100) n_led_chg++;
    end
    check("pause_hold_ticks", n_tick, 0);
    check("pause_hold_led", n_led_chg, 0);
    press(1'b0, 1'b1, HOLD);
    wait_to(77 + LAT - 1);
    check("pause_still", paused, 1'b1);
    wait_to(77 + LAT);
    check("pause_off", paused, 1'b0);
    wait_to(77 + LAT + 5);
    check("resume_no_tick", step_tick, 1'b0);
    wait_to(77 + LAT + 6);
    check("resume_tick", step_tick, 1'b1);
    check("resume_led", led, 4'b1000);

    // Simultaneous mode+pause in BLINK, then asynchronous reset.
    do_reset();
    press(1'b1, 1'b0, HOLD);
    wait_to(20);
    press(1'b1, 1'b0, HOLD);
    wait_to(20 + LAT + 11);
    check("both_pre_mode", mode, 2'd2);
    check("both_pre_led", led, 4'b0000);
    t_mp = 20 + LAT + 12;
    wait_to(t_mp);
    press(1'b1, 1'b1, HOLD);
    wait_to(t_mp + LAT);
    check("both_mode", mode, 2'd3);
    check("both_led", led, 4'b0001);
    check("both_paused", paused, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", led, 4'b0001);
    check("async_rst_mode", mode, 2'd0);
    check("async_rst_paused", paused, 1'b0);
    check("async_rst_tick", step_tick, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
